// File: rtl/draw_scheduler_if.sv
// Sprite client handshake and VGA pixel bus bundle.
// master = scheduler side, slave = sprite clients / pixel sink.
interface draw_scheduler_if #(
    parameter int N_OBJ = 3
);
    logic [8*N_OBJ-1:0]  cl_x;
    logic [7*N_OBJ-1:0]  cl_y;
    logic [24*N_OBJ-1:0] cl_colour;
    logic [N_OBJ-1:0]    cl_writeEn;
    logic [N_OBJ-1:0]    cl_done;
    logic [N_OBJ-1:0]    cl_active;
    logic [N_OBJ-1:0]    cl_start;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [23:0]         vga_colour;
    logic                vga_plot;
    logic                frame_tick;
    logic                overrun;

    modport master (
        input  cl_x, cl_y, cl_colour, cl_writeEn, cl_done,
        output cl_active, cl_start,
        output vga_x, vga_y, vga_colour, vga_plot,
        output frame_tick, overrun
    );

    modport slave (
        output cl_x, cl_y, cl_colour, cl_writeEn, cl_done,
        input  cl_active, cl_start,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  frame_tick, overrun
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame erase/draw scheduler owning the single VGA pixel port.
// Optional per-grant watchdog: define DRAW_SCHED_TIMEOUT_EN.
module draw_scheduler #(
    parameter int N_OBJ     = 3,
    parameter int FRAME_DIV = 833333,
    parameter int TIMEOUT   = 4095
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    draw_scheduler_if.master bus
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [2:0] SEL_LAST = 3'(N_OBJ - 1);

    typedef enum logic [2:0] {
        DRAW_REQ,
        DRAW_NEXT,
        WAIT_TICK,
        ERASE_REQ,
        ERASE_BUSY,
        ERASE_NEXT
    } state_t;

    state_t state, state_nxt;
    logic [2:0] sel, sel_nxt;
    logic seen, seen_nxt;
    logic [DIV_W-1:0] div;
    logic tick;
    logic pending;
    logic overrun_q;
    logic consume;
    logic skip;
    logic wd_hit;

    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [23:0] sel_colour;
    logic        sel_we;
    logic        sel_done;

    logic [N_OBJ-1:0] active_nxt, start_nxt;
    logic [N_OBJ-1:0] active_q, start_q;
    logic [7:0]  vx_q;
    logic [6:0]  vy_q;
    logic [23:0] vc_q;
    logic        plot_q;
    logic        bus_owned;

    assign tick = (div == DIV_LAST);

    // frame divider: 0..FRAME_DIV-1, tick on the wrap cycle
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

`ifdef DRAW_SCHED_TIMEOUT_EN
    logic [11:0] wd;
    logic        wd_run;

    assign wd_run = (state == DRAW_REQ) || (state == ERASE_REQ)
                 || (state == ERASE_BUSY);
    assign wd_hit = wd_run && (wd == 12'(TIMEOUT - 1));

    // watchdog: restarts on each state change, counts while a grant is held
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wd <= '0;
        end else if (state_nxt != state) begin
            wd <= '0;
        end else if (wd_run) begin
            wd <= wd + 12'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // pick the selected client's fields without out-of-range slices
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_we     = 1'b0;
        sel_done   = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (sel == 3'(i)) begin
                sel_x      = bus.cl_x[8*i +: 8];
                sel_y      = bus.cl_y[7*i +: 7];
                sel_colour = bus.cl_colour[24*i +: 24];
                sel_we     = bus.cl_writeEn[i];
                sel_done   = bus.cl_done[i];
            end
        end
    end

    // next-state logic for the erase-then-draw schedule
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        seen_nxt  = seen;
        consume   = 1'b0;
        skip      = 1'b0;
        unique case (state)
            DRAW_REQ: begin
                if (sel_done) begin
                    state_nxt = DRAW_NEXT;
                end else if (wd_hit) begin
                    state_nxt = DRAW_NEXT;
                    skip      = 1'b1;
                end
            end
            DRAW_NEXT: begin
                if (sel == SEL_LAST) begin
                    sel_nxt   = 3'd0;
                    state_nxt = WAIT_TICK;
                end else begin
                    sel_nxt   = sel + 3'd1;
                    state_nxt = DRAW_REQ;
                end
            end
            WAIT_TICK: begin
                if (pending) begin
                    consume   = 1'b1;
                    state_nxt = ERASE_REQ;
                end
            end
            ERASE_REQ: begin
                if (!sel_done) begin
                    state_nxt = ERASE_BUSY;
                end else if (wd_hit) begin
                    state_nxt = ERASE_NEXT;
                    skip      = 1'b1;
                end
            end
            ERASE_BUSY: begin
                if (seen && !sel_we) begin
                    seen_nxt  = 1'b0;
                    state_nxt = ERASE_NEXT;
                end else if (wd_hit) begin
                    seen_nxt  = 1'b0;
                    state_nxt = ERASE_NEXT;
                    skip      = 1'b1;
                end else if (sel_we) begin
                    seen_nxt = 1'b1;
                end
            end
            ERASE_NEXT: begin
                if (sel == SEL_LAST) begin
                    sel_nxt   = 3'd0;
                    state_nxt = DRAW_REQ;
                end else begin
                    sel_nxt   = sel + 3'd1;
                    state_nxt = ERASE_REQ;
                end
            end
            default: begin
                sel_nxt   = 3'd0;
                seen_nxt  = 1'b0;
                state_nxt = DRAW_REQ;
            end
        endcase
    end

    // grants follow the next state so they line up with the state register
    always_comb begin
        active_nxt = '0;
        start_nxt  = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (sel_nxt == 3'(i)) begin
                active_nxt[i] = (state_nxt == DRAW_REQ);
                start_nxt[i]  = (state_nxt == ERASE_REQ);
            end
        end
    end

    // FSM state, client index and grant registers
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state    <= DRAW_REQ;
            sel      <= 3'd0;
            seen     <= 1'b0;
            active_q <= '0;
            start_q  <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            seen     <= seen_nxt;
            active_q <= active_nxt;
            start_q  <= start_nxt;
        end
    end

    // pending frame flag and sticky overrun
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            pending   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (tick) begin
                pending <= 1'b1;
                if (pending && !consume) begin
                    overrun_q <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
            if (skip) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus_owned = (state == DRAW_REQ) || (state == ERASE_REQ)
                    || (state == ERASE_BUSY);

    // one-cycle pixel mux; all four fields captured on the same edge
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            vx_q   <= '0;
            vy_q   <= '0;
            vc_q   <= '0;
            plot_q <= 1'b0;
        end else if (bus_owned) begin
            vx_q   <= sel_x;
            vy_q   <= sel_y;
            vc_q   <= sel_colour;
            plot_q <= sel_we;
        end else begin
            plot_q <= 1'b0;
        end
    end

    assign bus.cl_active  = active_q;
    assign bus.cl_start   = start_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.vga_colour = vc_q;
    assign bus.vga_plot   = plot_q;
    assign bus.frame_tick = tick;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler with three model sprite clients.
// Clients push expected pixels; a monitor pops them off the VGA port.
module tb_draw_scheduler;
    localparam int N  = 3;
    localparam int FD = 1000;
    localparam int TO = 4095;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] c;
        logic [31:0] cyc;
    } pix_t;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    draw_scheduler_if #(.N_OBJ(N)) bus ();

    draw_scheduler #(
        .N_OBJ(N),
        .FRAME_DIV(FD),
        .TIMEOUT(TO)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .bus(bus)
    );

    pix_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [31:0] cyc = 0;
    int ph[N];
    int cnt[N];
    int wt[N];
    bit mute[N];
    int npx = 1024;
    bit rnd = 1'b0;
    int plot_cnt = 0;
    int ers_cnt = 0;
    logic [31:0] last_tick = 0;
    bit chk_sync = 1'b0;
    int sync_cnt = 0;
    logic prev_st0 = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input int p, input bit ers);
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] c;
        x = 8'(40 * i + p % 32);
        y = 7'(p / 32 + 10 * i);
        c = ers ? 24'hFFFFFF : 24'(32'h100000 * (i + 1) + p);
        bus.cl_x[8*i +: 8]       = x;
        bus.cl_y[7*i +: 7]       = y;
        bus.cl_colour[24*i +: 24] = c;
        bus.cl_writeEn[i]        = 1'b1;
        sb.push_back('{x: x, y: y, c: c, cyc: cyc});
    endtask

    task automatic step(input int i);
        bus.cl_writeEn[i] = 1'b0;
        if (!resetn) begin
            ph[i]  = 0;
            cnt[i] = 0;
            bus.cl_done[i] = rnd ? 1'($urandom) : 1'b0;
            if (rnd) begin
                bus.cl_writeEn[i]        = 1'($urandom);
                bus.cl_x[8*i +: 8]       = 8'($urandom);
                bus.cl_y[7*i +: 7]       = 7'($urandom);
                bus.cl_colour[24*i +: 24] = 24'($urandom);
            end
            return;
        end
        if (ph[i] == 0 && bus.cl_active[i] && !mute[i]) begin
            ph[i]  = 1;
            cnt[i] = 0;
        end
        if (ph[i] == 1) begin
            if (cnt[i] == npx) begin
                bus.cl_done[i] = 1'b1;
                ph[i] = 2;
                wt[i] = 0;
            end else begin
                drive(i, cnt[i], 1'b0);
                cnt[i]++;
            end
        end else if (ph[i] == 2) begin
            wt[i]++;
            if (bus.cl_start[i]) begin
                bus.cl_done[i] = 1'b0;
                ph[i]  = 3;
                cnt[i] = 0;
            end else if (wt[i] >= 2 && wt[i] % 8 == 0) begin
                bus.cl_colour[24*i +: 24] = 24'h0BAD00;
                bus.cl_writeEn[i] = 1'b1;
            end
        end else if (ph[i] == 3) begin
            if (cnt[i] == npx + 1) begin
                ph[i] = 0;
            end else begin
                drive(i, cnt[i], 1'b1);
                cnt[i]++;
            end
        end
    endtask

    initial begin
        bus.cl_x = '0;
        bus.cl_y = '0;
        bus.cl_colour = '0;
        bus.cl_writeEn = '0;
        bus.cl_done = '0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            for (int i = 0; i < N; i++) step(i);
        end
    end

    initial begin
        pix_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            chk("grant_onehot",
                96'($onehot0({bus.cl_active, bus.cl_start})), 96'd1);
            if (bus.frame_tick) begin
                if (last_tick != 0)
                    chk("tick_period", 96'(cyc - last_tick), 96'(FD));
                last_tick = cyc;
            end
            if (bus.cl_start[0] && !prev_st0 && chk_sync) begin
                chk("erase_after_tick",
                    96'((cyc - last_tick) <= 2), 96'd1);
                sync_cnt++;
            end
            prev_st0 = bus.cl_start[0];
            if (bus.vga_plot) begin
                plot_cnt++;
                if (bus.vga_colour == 24'hFFFFFF) ers_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_plot: got x=%0h y=%0h c=%0h expected none",
                             bus.vga_x, bus.vga_y, bus.vga_colour);
                end else begin
                    e = sb.pop_front();
                    chk("pixel",
                        {bus.vga_x, bus.vga_y, bus.vga_colour, cyc},
                        {e.x, e.y, e.c, e.cyc + 32'd1});
                end
            end
        end
    end

    task automatic wait_all(input int p, input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (ph[i] != p) ok = 1'b0;
        end
        chk(name, 96'(ok), 96'd1);
    endtask

    initial begin
        bit ok;
        logic [31:0] t0;
        for (int i = 0; i < N; i++) mute[i] = 1'b0;
        resetn = 1'b0;
        rnd = 1'b1;
        repeat (2) begin
            @(negedge CLOCK_50);
            chk("reset_outs",
                96'({bus.cl_active, bus.cl_start, bus.vga_x, bus.vga_y,
                     bus.vga_colour, bus.vga_plot, bus.frame_tick,
                     bus.overrun}), 96'd0);
        end
        rnd = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        sb.delete();
        plot_cnt = 0;
        ers_cnt = 0;
        @(negedge CLOCK_50);
        chk("active_after_reset", 96'(bus.cl_active), 96'b001);

        wait_all(2, 5000, "draw_pass_done");
        chk("draw_plot_count", 96'(plot_cnt), 96'd3072);
        chk("overrun_set", 96'(bus.overrun), 96'd1);

        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = (ph[1] == 3);
        end
        chk("erase1_start", 96'(ok), 96'd1);
        chk("erase0_count", 96'(ers_cnt), 96'd1025);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = (ph[1] == 3 && cnt[1] >= 500);
        end
        chk("erase1_mid", 96'(ok), 96'd1);
        chk("overrun_sticky", 96'(bus.overrun), 96'd1);

        resetn = 1'b0;
        sb.delete();
        @(negedge CLOCK_50);
        chk("reset_mid_plot", 96'(bus.vga_plot), 96'd0);
        chk("reset_mid_start", 96'(bus.cl_start), 96'd0);
        chk("reset_mid_overrun", 96'(bus.overrun), 96'd0);
        npx = 8;
        last_tick = 0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        sb.delete();
        @(negedge CLOCK_50);
        chk("active_after_reset2", 96'(bus.cl_active), 96'b001);

        chk_sync = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = (sync_cnt >= 3);
        end
        chk("three_frames", 96'(ok), 96'd1);
        chk("no_overrun_small", 96'(bus.overrun), 96'd0);
        chk_sync = 1'b0;

`ifdef DRAW_SCHED_TIMEOUT_EN
        mute[1] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = (bus.cl_active == 3'b010 && ph[1] == 0);
        end
        chk("mute_grant", 96'(ok), 96'd1);
        t0 = cyc;
        ok = 1'b0;
        for (int k = 0; k < TO + 200 && !ok; k++) begin
            @(negedge CLOCK_50);
            ok = (bus.cl_active == 3'b100);
        end
        chk("timeout_skip", 96'(ok), 96'd1);
        chk("timeout_latency", 96'(cyc - t0), 96'(TO + 1));
        chk("timeout_overrun", 96'(bus.overrun), 96'd1);
`else
        t0 = cyc;
`endif
        repeat (4) @(negedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
